pencode_scan: RTL and testbench
===============================

PENCODE_SCAN -- requirements
Module: pencode_scan

Interface
REQ-001 Parameter WIDTH, default 16, input vector width; SHALL be a power of two, 2..256.
REQ-002 Parameter IDX_W, default $clog2(WIDTH), index width; SHALL be derived and never overridden.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 in_valid  input  1  d_in offered.
REQ-006 in_ready  output  1  block can capture d_in.
REQ-007 d_in  input  WIDTH  request vector; bit WIDTH-1 has highest priority.
REQ-008 out_valid  output  1  y, last and none are valid.
REQ-009 out_ready  input  1  consumer accepts the current beat.
REQ-010 y  output  IDX_W  index of the highest-priority pending bit.
REQ-011 last  output  1  current beat is the final beat for the captured vector.
REQ-012 none  output  1  captured vector was all-zero.

Function
REQ-013 Block SHALL emit, one beat per handshake, the index of every set bit of a captured vector, highest index first.
REQ-014 FSM SHALL have exactly two states: IDLE and SCAN.
REQ-015 IDLE: in_ready=1, out_valid=0; on in_valid=1, SHALL load d_in into pending register P and go to SCAN.
REQ-016 SCAN: in_ready=0, out_valid=1; in_valid SHALL be ignored.
REQ-017 First out_valid SHALL assert on the cycle after the input handshake (latency 1).
REQ-018 In SCAN with P!=0: y = highest set index of P; last = 1 iff P has exactly one bit set; none = 0.
REQ-019 In SCAN with P==0: y=0, last=1, none=1; exactly one beat SHALL be emitted.
REQ-020 On out_valid&out_ready: bit y of P SHALL clear; if last=1, return to IDLE on the same edge.
REQ-021 With out_ready=0, y/last/none/out_valid SHALL hold stable.
REQ-022 Next input SHALL be accepted no earlier than the cycle after the last-beat handshake; minimum period is (popcount+1) cycles per vector, with zero vectors taking 2 cycles.
REQ-023 y/last/none SHALL be combinational from P only; no combinational path from in_valid or d_in to any output.
REQ-024 Outside SCAN, y=0, last=0, none=0.

Reset
REQ-025 With rst_n=0: state=IDLE, P=0, out_valid=0, in_ready=0, y=0, last=0, none=0, irrespective of clk.
REQ-026 After rst_n deasserts, in_ready SHALL rise at the first clk edge.
REQ-027 Reset mid-SCAN SHALL discard all pending bits; no beat emitted after reset deassertion until a new capture.

Configuration
REQ-028 Macro PENCODE_SCAN_COUNT_EN defined: output hit_cnt (IDX_W+1 bits) SHALL equal popcount of d_in, registered at capture, held through SCAN, 0 in IDLE and at reset.
REQ-029 Macro PENCODE_SCAN_COUNT_EN undefined: hit_cnt port and its logic SHALL not exist; all other behaviour identical.

Verification (WIDTH=16)
REQ-030 Walking-one d_in=16'h0001..16'h8000, out_ready=1 -> one beat each, y=0..15, last=1, none=0.
REQ-031 d_in=16'h400A, out_ready=1 -> beats y=14,3,1; last=0,0,1; in_ready returns 1 the cycle after y=1.
REQ-032 d_in=16'h6202, out_ready toggled 1,0,1,0... -> y=14,13,9,1 in order, each held stable while out_ready=0; hit_cnt=4 when PENCODE_SCAN_COUNT_EN is defined.
REQ-033 d_in=16'h0000 -> single beat y=0, none=1, last=1; then IDLE.
REQ-034 d_in=16'hFFFF, rst_n pulsed low after beat y=12 -> out_valid=0 immediately; after release, in_ready=1, no stray beats.
REQ-035 in_valid held 1 with changing d_in during SCAN -> values ignored; next capture only in IDLE.

Source files
------------

// File: rtl/pencode_scan.sv
// pencode_scan: serialising priority encoder.
// A captured request vector is replayed as a stream of beats, one per
// output handshake, each carrying the index of the highest remaining set
// bit. Bit WIDTH-1 has the highest priority. An all-zero vector produces a
// single beat flagged with `none`.
//
// Optional feature: define PENCODE_SCAN_COUNT_EN to add the hit_cnt output.
// It carries the popcount of the captured vector while a scan is in
// progress and reads zero otherwise.
module pencode_scan #(
  parameter int WIDTH = 16,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] d_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] y,
  output logic             last,
  output logic             none
`ifdef PENCODE_SCAN_COUNT_EN
  ,
  output logic [IDX_W:0]   hit_cnt
`endif
);

  // Catch illegal parameterisations at elaboration time.
  generate
    if (WIDTH < 2 || WIDTH > 256 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
      $error("pencode_scan: WIDTH must be a power of two in 2..256");
    end
    if (IDX_W != $clog2(WIDTH)) begin : g_bad_idx_w
      $error("pencode_scan: IDX_W must equal $clog2(WIDTH)");
    end
  endgenerate

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] pend_reg;
  logic [WIDTH-1:0] pend_next;
  logic             init_reg;

  logic             scan;
  logic             capture;
  logic             beat_done;

  // above[i]: some pending bit with a higher index than i is set.
  // onehot:   isolates the highest-priority pending bit (zero if P==0).
  logic [WIDTH-1:0]             above;
  logic [WIDTH-1:0]             onehot;
  logic [IDX_W-1:0][WIDTH-1:0]  sel;
  logic [IDX_W-1:0]             y_enc;

  // Highest-priority isolation, built bit by bit from the pending register.
  genvar gi;
  genvar bi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_isolate
      if (gi == WIDTH - 1) begin : g_top
        assign above[gi] = 1'b0;
      end else begin : g_lower
        assign above[gi] = |pend_reg[WIDTH-1:gi+1];
      end
      assign onehot[gi] = pend_reg[gi] & ~above[gi];
    end
  endgenerate

  // One-hot to binary: output bit bi is the OR of every one-hot position
  // whose index has bit bi set.
  generate
    for (bi = 0; bi < IDX_W; bi++) begin : g_ybit
      for (gi = 0; gi < WIDTH; gi++) begin : g_sel
        if (((gi >> bi) & 1) == 1) begin : g_on
          assign sel[bi][gi] = onehot[gi];
        end else begin : g_off
          assign sel[bi][gi] = 1'b0;
        end
      end
      assign y_enc[bi] = |sel[bi];
    end
  endgenerate

  // Handshake qualifiers. in_ready stays low until the first clock edge
  // after reset release, so nothing is accepted while reset is settling.
  assign scan      = (state_reg == SCAN);
  assign in_ready  = init_reg && (state_reg == IDLE);
  assign out_valid = scan;
  assign capture   = in_ready && in_valid;
  assign beat_done = scan && out_ready;

  // Beat outputs depend on the pending register and state only; they are
  // forced to zero outside SCAN. last covers both "one bit left" and the
  // all-zero case, where onehot is also zero.
  assign y    = scan ? y_enc : '0;
  assign last = scan && (pend_reg == onehot);
  assign none = scan && (pend_reg == '0);

  // Next-state and pending-register update.
  always_comb begin
    state_next = state_reg;
    pend_next  = pend_reg;
    case (state_reg)
      IDLE: begin
        if (capture) begin
          pend_next  = d_in;
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (out_ready) begin
          pend_next = pend_reg & ~onehot;
          if (last) begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        pend_next  = '0;
      end
    endcase
  end

  // State and pending register; reset discards any scan in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      pend_reg  <= '0;
    end else begin
      state_reg <= state_next;
      pend_reg  <= pend_next;
    end
  end

  // Becomes set on the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_reg <= 1'b0;
    end else begin
      init_reg <= 1'b1;
    end
  end

`ifdef PENCODE_SCAN_COUNT_EN
  logic [IDX_W:0] cnt_reg;
  logic [IDX_W:0] pop_d;

  // Popcount of the incoming vector, only registered on capture.
  always_comb begin
    pop_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop_d = pop_d + {{IDX_W{1'b0}}, d_in[i]};
    end
  end

  // Count is loaded on capture, held through SCAN, cleared on the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (capture) begin
      cnt_reg <= pop_d;
    end else if (beat_done && last) begin
      cnt_reg <= '0;
    end
  end

  assign hit_cnt = cnt_reg;
`endif

endmodule

// File: tb/tb_pencode_scan.sv
// tb_pencode_scan: self-checking bench for pencode_scan (WIDTH=16).
// A queue-based reference model predicts every output on every cycle;
// a vector table and hand-written sequences add explicit beat checks.
module tb_pencode_scan;
  localparam int WIDTH = 16;
  localparam int IDX_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] d_in = '0;
  logic             in_ready;
  logic             out_valid;
  logic             last;
  logic             none;
  logic [IDX_W-1:0] y;
`ifdef PENCODE_SCAN_COUNT_EN
  logic [IDX_W:0]   hit_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pencode_scan #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d_in      (d_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .last      (last),
    .none      (none)
`ifdef PENCODE_SCAN_COUNT_EN
    ,
    .hit_cnt   (hit_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: pending indices as a descending queue.
  int m_q[$];
  bit m_busy;
  bit m_zero;
  bit m_init;
  int m_cnt;

  int obs_y[$];
  bit obs_last[$];
  bit obs_none[$];

  task automatic model_reset();
    m_q.delete();
    m_busy = 1'b0;
    m_zero = 1'b0;
    m_init = 1'b0;
    m_cnt  = 0;
  endtask

  task automatic check_outputs(input string tag);
    int ey;
    ey = (m_busy && m_q.size() > 0) ? m_q[0] : 0;
    check({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, (m_init && !m_busy)});
    check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, m_busy});
    check({tag, ".y"},         {28'd0, y},         ey);
    check({tag, ".last"},      {31'd0, last},      {31'd0, (m_busy && m_q.size() <= 1)});
    check({tag, ".none"},      {31'd0, none},      {31'd0, (m_busy && m_zero)});
`ifdef PENCODE_SCAN_COUNT_EN
    check({tag, ".hit_cnt"},   {27'd0, hit_cnt},   m_busy ? m_cnt : 0);
`endif
  endtask

  // Check the current outputs, log handshaken beats, advance the model over
  // the coming edge, then step to 1 time unit after that edge.
  task automatic cycle(input string tag);
    bit was_init;
    check_outputs(tag);
    if (out_valid === 1'b1 && out_ready) begin
      obs_y.push_back(int'(y));
      obs_last.push_back(last);
      obs_none.push_back(none);
    end
    was_init = m_init;
    m_init = 1'b1;
    if (!m_busy) begin
      if (in_valid && was_init) begin
        m_q.delete();
        for (int i = WIDTH - 1; i >= 0; i--) if (d_in[i]) m_q.push_back(i);
        m_zero = (m_q.size() == 0);
        m_cnt  = m_q.size();
        m_busy = 1'b1;
      end
    end else if (out_ready) begin
      if (m_q.size() > 0) void'(m_q.pop_front());
      if (m_q.size() == 0) begin
        m_busy = 1'b0;
        m_zero = 1'b0;
        m_cnt  = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse: outputs must clear without a clock edge.
  task automatic reset_pulse(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs({tag, ".async"});
    @(posedge clk);
    #1;
    check_outputs({tag, ".held"});
    rst_n = 1'b1;
  endtask

  // Offer d until captured, then drain with out_ready per mode
  // (0: always 1, 1: toggling 1,0,1,0...). Returns scan cycles used.
  task automatic run_vector(input logic [WIDTH-1:0] d, input int mode, input string tag, output int ncyc);
    int n;
    obs_y.delete();
    obs_last.delete();
    obs_none.delete();
    in_valid  = 1'b1;
    d_in      = d;
    out_ready = 1'b1;
    n = 0;
    do begin
      cycle({tag, ".cap"});
      n++;
    end while (!m_busy && n < 8);
    check({tag, ".captured"}, {31'd0, m_busy}, 32'd1);
    in_valid = 1'b0;
    d_in     = WIDTH'($urandom);
`ifdef PENCODE_SCAN_COUNT_EN
    check({tag, ".hit_cnt_cap"}, {27'd0, hit_cnt}, $countones(d));
`endif
    n = 0;
    while (m_busy && n < 64) begin
      out_ready = (mode == 0) ? 1'b1 : ((n % 2) == 0);
      cycle({tag, ".scan"});
      n++;
    end
    check({tag, ".drain_bound"}, {31'd0, m_busy}, 32'd0);
    out_ready = 1'b1;
    ncyc = n;
  endtask

  function automatic int obs_at(input int k);
    return (k >= 0 && k < obs_y.size()) ? obs_y[k] : -1;
  endfunction

  typedef struct {
    logic [15:0] d;
    int          beats;
    int          first_y;
    int          last_y;
    bit          none;
  } vec_t;

  vec_t tbl[$];

  initial begin
    vec_t v;
    int   ncyc;
    int   exp_seq[$];
    logic [15:0] w;

    // Walking ones, then multi-bit and boundary vectors.
    for (int i = 0; i < 16; i++) begin
      w = 16'h0001 << i;
      v = '{d: w, beats: 1, first_y: i, last_y: i, none: 1'b0};
      tbl.push_back(v);
    end
    tbl.push_back('{d: 16'h400A, beats: 3,  first_y: 14, last_y: 1,  none: 1'b0});
    tbl.push_back('{d: 16'h6202, beats: 4,  first_y: 14, last_y: 1,  none: 1'b0});
    tbl.push_back('{d: 16'h0000, beats: 1,  first_y: 0,  last_y: 0,  none: 1'b1});
    tbl.push_back('{d: 16'hFFFF, beats: 16, first_y: 15, last_y: 0,  none: 1'b0});
    tbl.push_back('{d: 16'h8001, beats: 2,  first_y: 15, last_y: 0,  none: 1'b0});

    #2;
    reset_pulse("reset0");

    // Table-driven vectors with out_ready held high.
    for (int k = 0; k < tbl.size(); k++) begin
      run_vector(tbl[k].d, 0, $sformatf("tbl%0d", k), ncyc);
      check($sformatf("tbl%0d.beats", k), obs_y.size(), tbl[k].beats);
      check($sformatf("tbl%0d.first_y", k), obs_at(0), tbl[k].first_y);
      check($sformatf("tbl%0d.last_y", k), obs_at(obs_y.size() - 1), tbl[k].last_y);
      check($sformatf("tbl%0d.none", k), (obs_none.size() > 0) ? {31'd0, obs_none[0]} : 32'hFFFF, {31'd0, tbl[k].none});
      check($sformatf("tbl%0d.final_last", k), (obs_last.size() > 0) ? {31'd0, obs_last[obs_last.size()-1]} : 32'hFFFF, 32'd1);
    end

    // 400A: beats 14,3,1 with last 0,0,1; in_ready back right after y=1.
    run_vector(16'h400A, 0, "seq400a", ncyc);
    check("seq400a.scan_cycles", ncyc, 3);
    check("seq400a.ready_back", {31'd0, in_ready}, 32'd1);
    check("seq400a.last0", (obs_last.size() == 3) ? {31'd0, obs_last[0]} : 32'hFFFF, 32'd0);
    check("seq400a.last1", (obs_last.size() == 3) ? {31'd0, obs_last[1]} : 32'hFFFF, 32'd0);
    check("seq400a.y1", obs_at(1), 3);

    // 6202 with out_ready toggling: order 14,13,9,1, held while stalled.
    run_vector(16'h6202, 1, "seq6202", ncyc);
    exp_seq = '{14, 13, 9, 1};
    check("seq6202.beats", obs_y.size(), 4);
    for (int k = 0; k < 4; k++) check($sformatf("seq6202.y%0d", k), obs_at(k), exp_seq[k]);
    check("seq6202.scan_cycles", ncyc, 7);

    // FFFF with reset asserted after beat y=12 has been accepted.
    obs_y.delete();
    in_valid = 1'b1;
    d_in = 16'hFFFF;
    cycle("seqffff.cap");
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) cycle("seqffff.beat");
    check("seqffff.pre_reset_y", {28'd0, y}, 32'd11);
    reset_pulse("seqffff.rst");
    for (int k = 0; k < 6; k++) cycle("seqffff.after");
    check("seqffff.beats_before_reset", obs_y.size(), 4);

    // in_valid held high with changing data during SCAN.
    in_valid = 1'b1;
    d_in = 16'h0003;
    cycle("hold.cap");
    for (int k = 0; k < 12; k++) begin
      d_in = WIDTH'($urandom);
      out_ready = 1'b1;
      cycle("hold.scan");
    end
    in_valid = 1'b0;
    for (int k = 0; k < 40 && m_busy; k++) cycle("hold.drain");

    // Randomised traffic against the model, with occasional resets.
    for (int k = 0; k < 1500; k++) begin
      in_valid = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 3))
        0:       d_in = '0;
        1:       d_in = WIDTH'($urandom) & WIDTH'($urandom) & WIDTH'($urandom);
        default: d_in = WIDTH'($urandom);
      endcase
      out_ready = ($urandom_range(0, 3) != 0);
      if (k % 397 == 396) reset_pulse("rnd.rst");
      else cycle("rnd");
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 40 && m_busy; k++) cycle("rnd.drain");
    cycle("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
